// File: rtl/glb_stream_arbiter.sv
// Round-robin block arbiter: grants whole length-prefixed blocks from NUM_PORTS
// streams onto one GLB read stream and signals done once each port's quota has been sent.
module glb_stream_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BLK_CNT_W  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [NUM_PORTS*BLK_CNT_W-1:0]  num_blocks,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(NUM_PORTS)-1:0]    out_port_id,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);
    localparam int unsigned PORT_W = $clog2(NUM_PORTS);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_HEADER, S_PAYLOAD, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PORT_W-1:0]     grant_q, grant_d;
    logic [BLK_CNT_W-1:0]  remaining_q [NUM_PORTS];
    logic [BLK_CNT_W-1:0]  remaining_d [NUM_PORTS];
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

    logic                  pick_found;
    logic [PORT_W-1:0]     pick_idx;
    logic                  all_zero;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  grant_valid;
    logic                  path_en;
    logic                  hs;
    logic                  block_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            remaining_q <= '{default: '0};
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
        end
    end

    // Round-robin search from rr_ptr over ports that are valid and still owe blocks
    always_comb begin
        logic [PORT_W-1:0] idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        all_zero   = 1'b1;
        idx        = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (remaining_q[PORT_W'(k)] != '0) all_zero = 1'b0;
            idx = PORT_W'((32'(rr_ptr_q) + k) % NUM_PORTS);
            if (!pick_found && in_valid[idx] && (remaining_q[idx] != '0)) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // Granted-port data/valid mux
    always_comb begin
        grant_data  = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (PORT_W'(k) == grant_q) begin
                grant_data  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                grant_valid = in_valid[k];
            end
        end
    end

    // Next-state logic; flush overrides every state
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        block_done  = 1'b0;
        if (flush) begin
            state_d  = S_ARB;
            rr_ptr_d = '0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                remaining_d[PORT_W'(k)] = num_blocks[k*BLK_CNT_W +: BLK_CNT_W];
            end
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ARB: begin
                    if (all_zero) begin
                        state_d = S_DONE;
                    end else if (pick_found) begin
                        grant_d = pick_idx;
                        state_d = S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (hs) begin
                        if (grant_data == '0) begin
                            block_done = 1'b1;
                        end else begin
                            cnt_d   = grant_data;
                            state_d = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (hs) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == DATA_WIDTH'(1)) block_done = 1'b1;
                    end
                end
                S_DONE: ;
                default: state_d = S_IDLE;
            endcase
            if (block_done) begin
                remaining_d[grant_q] = remaining_q[grant_q] - 1'b1;
                rr_ptr_d = (grant_q == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                state_d  = S_ARB;
            end
        end
    end

    // Outputs: zero-latency pass-through of the granted stream, masked by reset/flush
    always_comb begin
        busy        = !reset && ((state_q == S_HEADER) || (state_q == S_PAYLOAD));
        path_en     = busy && !flush;
        out_valid   = path_en && grant_valid;
        out_data    = grant_data;
        in_ready    = '0;
        if (path_en) in_ready[grant_q] = out_ready;
        out_port_id = busy ? grant_q : '0;
        out_last    = out_valid &&
                      (((state_q == S_HEADER) && (grant_data == '0)) ||
                       ((state_q == S_PAYLOAD) && (cnt_q == DATA_WIDTH'(1))));
        done        = !reset && (state_q == S_DONE);
        hs          = out_valid && out_ready;
    end

endmodule
